// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default frame format.
// Kept in one package so the transmitter and receiver agree on the line format.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_STOP_WIDTH = 1;
    localparam int DEF_OVERSAMPLE = 16;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// The reset value is a parameter so an idle-high serial line comes out of reset as 1.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop framing sampled at mid-bit on the oversampling tick.
// Emits each word with a one-cycle done strobe and a sticky-per-frame stop-bit error flag.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int STOP_WIDTH = DEF_STOP_WIDTH,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_tick,
    input  logic                  i_rx_data,
    output logic [DATA_WIDTH-1:0] o_data_byte,
    output logic                  o_rx_done_bit,
    output logic                  o_frame_err
);

    localparam int TW = cnt_width(OVERSAMPLE);
    localparam int BW = cnt_width(DATA_WIDTH);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST = 1'(STOP_WIDTH - 1);

    logic rx_s;
    logic rx_prev_q;

    rx_state_e             state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (i_rx_data),
        .o_q   (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            shift_q   <= '0;
            err_q     <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            shift_q   <= shift_d;
            err_q     <= err_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        err_d   = err_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;

        case (state_q)
            ST_IDLE: begin
                // Edge-triggered so a line stuck low (break) cannot restart a frame.
                if (rx_prev_q && !rx_s) begin
                    state_d = ST_START;
                    tick_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (tick_q == TICK_END) begin
                        shift_d                 = shift_q >> 1;
                        shift_d[DATA_WIDTH-1]   = rx_s;
                        tick_d                  = '0;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_STOP;
                            stop_d  = 1'b0;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (tick_q == TICK_END) begin
                        err_d  = err_q | ~rx_s;
                        tick_d = '0;
                        if (stop_q == STOP_LAST) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            data_d  = shift_q;
                            ferr_d  = err_q | ~rx_s;
                        end else begin
                            stop_d = stop_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_data_byte   = data_q;
    assign o_rx_done_bit = done_q;
    assign o_frame_err   = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are driven bit-by-bit on the serial line and every
// done strobe is scored against a queue of words/error flags predicted from the frame contents.
module tb_uart_rx;

    localparam int OS      = 16;
    localparam int TP      = 4;          // clocks per oversampling tick
    localparam int BIT_CLK = OS * TP;    // clocks per bit period

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b0;
    logic rx1 = 1'b1;
    logic rx2 = 1'b1;
    int   tick_cnt = 0;

    logic [7:0] data1, data2;
    logic       done1, done2, ferr1, ferr2;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp1[$];
    logic [8:0] exp2[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_cnt <= (tick_cnt == TP - 1) ? 0 : tick_cnt + 1;
        tick     <= (tick_cnt == TP - 1);
    end

    uart_rx #(.DATA_WIDTH(8), .STOP_WIDTH(1), .OVERSAMPLE(OS)) dut1 (
        .clk(clk), .reset(reset), .i_tick(tick), .i_rx_data(rx1),
        .o_data_byte(data1), .o_rx_done_bit(done1), .o_frame_err(ferr1)
    );

    uart_rx #(.DATA_WIDTH(8), .STOP_WIDTH(2), .OVERSAMPLE(OS)) dut2 (
        .clk(clk), .reset(reset), .i_tick(tick), .i_rx_data(rx2),
        .o_data_byte(data2), .o_rx_done_bit(done2), .o_frame_err(ferr2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboards: every strobe must match the oldest predicted frame and last one clock.
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (done1) begin
            check("dut1_strobe_width", prev1, 0);
            if (exp1.size() == 0) begin
                check("dut1_unexpected_strobe", 1, 0);
            end else begin
                e = exp1.pop_front();
                check("dut1_data", data1, e[7:0]);
                check("dut1_ferr", ferr1, e[8]);
            end
        end
        if (done2) begin
            check("dut2_strobe_width", prev2, 0);
            if (exp2.size() == 0) begin
                check("dut2_unexpected_strobe", 1, 0);
            end else begin
                e = exp2.pop_front();
                check("dut2_data", data2, e[7:0]);
                check("dut2_ferr", ferr2, e[8]);
            end
        end
        prev1 = done1;
        prev2 = done2;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic b, input int nclk);
        if (sel == 0) rx1 = b; else rx2 = b;
        wait_clks(nclk);
    endtask

    // Reference model: a frame's word is exactly the data bits sent, and its error flag
    // is set when any stop bit that was sent is 0.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic [1:0] stops,
                              input int nstop, input int gap_bits);
        logic ferr;
        ferr = 1'b0;
        for (int i = 0; i < nstop; i++) ferr |= ~stops[i];
        if (sel == 0) exp1.push_back({ferr, d}); else exp2.push_back({ferr, d});
        drive(sel, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive(sel, d[i], BIT_CLK);
        for (int i = 0; i < nstop; i++) drive(sel, stops[i], BIT_CLK);
        if (gap_bits > 0) drive(sel, 1'b1, gap_bits * BIT_CLK);
    endtask

    initial begin
        logic [7:0] hold_d;
        logic       hold_e;
        logic [7:0] rd;
        logic       rerr;
        logic [1:0] st;
        int         gap;
        logic [7:0] a5;

        wait_clks(5);
        reset = 1'b0;
        wait_clks(3);
        check("reset_data1", data1, 0);
        check("reset_done1", done1, 0);
        check("reset_ferr1", ferr1, 0);
        check("reset_data2", data2, 0);
        check("reset_ferr2", ferr2, 0);
        wait_clks(2 * BIT_CLK);

        send_frame(0, 8'hEA, 2'b11, 1, 1);

        hold_d = data1;
        hold_e = ferr1;
        drive(0, 1'b0, 3 * TP);
        drive(0, 1'b1, 2 * BIT_CLK);
        check("glitch_data_hold", data1, hold_d);
        check("glitch_ferr_hold", ferr1, hold_e);

        send_frame(0, 8'h5A, 2'b10, 1, 1);
        send_frame(0, 8'h3C, 2'b11, 1, 1);
        send_frame(0, 8'h00, 2'b11, 1, 0);
        send_frame(0, 8'hFF, 2'b11, 1, 1);

        // Break: all-zero frame with a low stop bit, line stays low for a while afterwards.
        send_frame(0, 8'h00, 2'b00, 1, 0);
        drive(0, 1'b0, 3 * BIT_CLK);
        drive(0, 1'b1, 2 * BIT_CLK);
        check("break_pending", exp1.size(), 0);

        // Reset in the middle of a frame: partial word is not predicted and must not appear.
        a5 = 8'hA5;
        drive(0, 1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive(0, a5[i], BIT_CLK);
        reset = 1'b1;
        rx1   = 1'b1;
        wait_clks(4);
        check("midreset_data", data1, 0);
        check("midreset_ferr", ferr1, 0);
        check("midreset_done", done1, 0);
        reset = 1'b0;
        wait_clks(2 * BIT_CLK);
        send_frame(0, 8'h55, 2'b11, 1, 1);

        for (int n = 0; n < 20; n++) begin
            rd   = 8'($urandom_range(0, 255));
            rerr = ($urandom_range(0, 3) == 0);
            gap  = rerr ? $urandom_range(1, 3) : $urandom_range(0, 2);
            send_frame(0, rd, rerr ? 2'b10 : 2'b11, 1, gap);
        end

        send_frame(1, 8'hC3, 2'b01, 2, 1);
        send_frame(1, 8'h96, 2'b11, 2, 1);
        for (int n = 0; n < 6; n++) begin
            rd  = 8'($urandom_range(0, 255));
            st  = 2'($urandom_range(0, 3));
            gap = (st == 2'b11) ? $urandom_range(0, 2) : $urandom_range(1, 2);
            send_frame(1, rd, st, 2, gap);
        end

        wait_clks(2 * BIT_CLK);
        check("dut1_pending", exp1.size(), 0);
        check("dut2_pending", exp2.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
